tff_count_ctrl: RTL and testbench
=================================

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, the number of T flip-flops in the controlled bank.
REQ-002 The `clk` port SHALL be an input, 1 bit wide, and the single clock; all state SHALL update on the rising edge.
REQ-003 The `rst` port SHALL be an input, 1 bit wide, and the reset; it SHALL be asynchronous and active-low.
REQ-004 The `start` port SHALL be an input, 1 bit wide, and request a new operation; it SHALL be sampled only in IDLE.
REQ-005 The `mode` port SHALL be an input, 2 bits wide, with encoding 00=UP, 01=DOWN, 10=LOAD, 11=CLEAR; it SHALL be sampled with `start`.
REQ-006 The `load_val` port SHALL be an input, WIDTH bits wide, and be the LOAD target; it SHALL be sampled with `start`.
REQ-007 The `limit` port SHALL be an input, WIDTH bits wide, and be the terminal value for UP/DOWN; it SHALL be sampled with `start`.
REQ-008 The `abort` port SHALL be an input, 1 bit wide, and terminate a RUN operation without asserting `done`.
REQ-009 The `q` port SHALL be an output, WIDTH bits wide, and be the bank state (the T flip-flop outputs).
REQ-010 The `t_vec` port SHALL be an output, WIDTH bits wide, and be the toggle vector currently driven into the bank.
REQ-011 The `busy` port SHALL be an output, 1 bit wide, and be high while in RUN.
REQ-012 The `done` port SHALL be an output, 1 bit wide, and be a one-cycle pulse on normal completion.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, with the following transitions:
- IDLE to RUN on `start`=1.
- RUN to DONE on completion.
- RUN to IDLE on `abort`.
- DONE to IDLE unconditionally.
REQ-014 On the accepting edge, the block SHALL latch `mode`, `load_val` and `limit` into internal registers; changes on these inputs afterwards SHALL have no effect until the next accept.
REQ-015 `t_vec` SHALL be combinational from the state and `q`, and SHALL be 0 in IDLE and DONE.
REQ-016 In RUN with mode UP and `q`≠`limit`, bit i of `t_vec` SHALL be 1 iff `q[i-1:0]` are all 1, with bit 0 always 1; `q` increments modulo 2^WIDTH each cycle.
REQ-017 In RUN with mode DOWN and `q`≠`limit`, bit i of `t_vec` SHALL be 1 iff `q[i-1:0]` are all 0, with bit 0 always 1; `q` decrements modulo 2^WIDTH each cycle.
REQ-018 In RUN with mode UP/DOWN and `q`==`limit`, `t_vec` SHALL be 0 and the next state SHALL be DONE.
REQ-019 Counting SHALL wrap: UP from 14 with `limit`=1 and WIDTH=4 SHALL pass through 15, 0 and 1.
REQ-020 If `q`==`limit` when `start` is accepted, the block SHALL spend exactly one RUN cycle with `t_vec`=0, then enter DONE.
REQ-021 In RUN with mode LOAD, `t_vec` SHALL equal `q` XOR `load_val` for exactly one cycle, then the FSM SHALL enter DONE; `q` equals `load_val` in DONE.
REQ-022 In RUN with mode CLEAR, `t_vec` SHALL equal `q` for exactly one cycle, then the FSM SHALL enter DONE; `q` equals 0 in DONE.
REQ-023 Latency SHALL be as follows for UP/DOWN:
- `busy` is high for |distance|+1 cycles.
- `done` is high on the cycle after the last RUN cycle.
REQ-024 Latency for LOAD/CLEAR SHALL be `busy` high for 1 cycle and `done` high for 1 cycle.
REQ-025 `start` in RUN or DONE SHALL be ignored and not queued.
REQ-026 `abort` in RUN SHALL force `t_vec`=0 that cycle, go to IDLE, leave `q` unchanged, and not pulse `done`.
REQ-027 If `abort` and completion occur in the same cycle, `abort` SHALL win.
REQ-028 `abort` outside RUN SHALL be ignored.

Reset
REQ-029 `rst`=0 SHALL asynchronously force the following:
- state to IDLE;
- `q` to 0 in every flip-flop;
- latched `mode`, `load_val` and `limit` to 0;
- `busy` and `done` to 0;
- `t_vec` to 0.
REQ-030 Reset asserted mid-RUN SHALL abandon the operation with no `done` pulse; the first `start` after reset release SHALL be accepted normally.

Structure
REQ-031 Package `tff_ctrl_pkg` SHALL hold the state enum (IDLE, RUN, DONE) and the mode constants (MODE_UP, MODE_DOWN, MODE_LOAD, MODE_CLEAR).
REQ-032 Sub-module `t_ff` SHALL be a single T flip-flop with ports `clk`, `rst` (async, active-low) and `t` and outputs `q` and `q_bar`, instantiated WIDTH times via generate, with bit i driven by `t_vec[i]`.
REQ-033 The controller FSM and the toggle-mask logic SHALL reside in `tff_count_ctrl`.

Verification
REQ-034 A bench SHALL cover the following scenarios; all use WIDTH=4.
- Reset, then UP with `limit`=3 from `q`=0: `q` reads 0,1,2,3; `busy`=1 for 4 cycles; `done` pulses once; `t_vec` sequence 0001,0011,0001,0000.
- DOWN with `limit`=14 from `q`=1: `q` reads 1,0,15,14; `t_vec` at `q`=0 is 1111; `done` pulses once.
- LOAD with `load_val`=1010 from `q`=0110: `t_vec`=1100 for one cycle; `q`=1010 in DONE; then CLEAR gives `t_vec`=1010 and `q`=0.
- UP with `limit`=9 from `q`=0, `abort` at `q`=5: `q` holds 5; FSM returns to IDLE; no `done`; a `start` pulsed during RUN is ignored.
- UP with `limit`=`q`=7: one RUN cycle with `t_vec`=0, then `done`; `q` stays 7.
- `rst` low mid-count at `q`=6: `q`=0, `busy`=0 and `done`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: FSM state enum and mode encodings shared by the T flip-flop count controller
package tff_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] MODE_UP = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;
endpackage

// File: rtl/t_ff.sv
// t_ff: single T flip-flop (clk, async active-low rst, toggle t) with q and q_bar outputs
module t_ff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic q_bar
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else if (t) q <= ~q;
  assign q_bar = ~q;
endmodule

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: FSM driving a bank of T flip-flops via t_vec (start/mode/load_val/limit/abort in; q/t_vec/busy/done out)
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);
  state_t state_q, state_d;
  logic [1:0] mode_q;
  logic [WIDTH-1:0] load_q, limit_q, qb_unused;
  logic at_lim, one_shot;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      mode_q <= '0;
      load_q <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        mode_q <= mode;
        load_q <= load_val;
        limit_q <= limit;
      end
    end
  assign at_lim = q == limit_q;
  assign one_shot = mode_q == MODE_LOAD || mode_q == MODE_CLEAR;
  always_comb begin
    state_d = state_q;
    t_vec = '0;
    case (state_q)
      IDLE: state_d = start ? RUN : IDLE;
      RUN: begin
        t_vec = abort ? '0 :
                mode_q == MODE_LOAD ? q ^ load_q :
                mode_q == MODE_CLEAR ? q :
                at_lim ? '0 :
                mode_q == MODE_UP ? q ^ (q + WIDTH'(1)) : q ^ (q - WIDTH'(1));
        state_d = abort ? IDLE : (one_shot || at_lim) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff u_ff (.clk(clk), .rst(rst), .t(t_vec[i]), .q(q[i]), .q_bar(qb_unused[i]));
  end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: randomized and directed self-checking bench against a plan-queue reference model
module tb_tff_count_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] load_val = 4'd0, limit = 4'd0, q, t_vec;
  logic busy, done;
  always #5 clk = ~clk;
  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .load_val(load_val),
    .limit(limit), .abort(abort), .q(q), .t_vec(t_vec), .busy(busy), .done(done)
  );
  typedef struct packed {logic b; logic d; logic [3:0] q; logic [3:0] t;} ent_t;
  ent_t plan[$];
  logic [3:0] q_m = 4'd0, oq, ot;
  logic ob, od;
  int cmp = 0, err = 0;
  logic [3:0] up_t[4] = '{4'd1, 4'd3, 4'd1, 4'd0};
  logic [3:0] up_q[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
  logic [3:0] dn_q[4] = '{4'd1, 4'd0, 4'd15, 4'd14};
  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic build(input logic [1:0] m, input logic [3:0] lv, input logic [3:0] lim);
    int x, y;
    x = int'(q_m);
    if (m == 2'd2) begin
      plan.push_back('{1'b1, 1'b0, q_m, q_m ^ lv});
      plan.push_back('{1'b0, 1'b1, lv, 4'd0});
    end else if (m == 2'd3) begin
      plan.push_back('{1'b1, 1'b0, q_m, q_m});
      plan.push_back('{1'b0, 1'b1, 4'd0, 4'd0});
    end else begin
      while (x != int'(lim)) begin
        y = m == 2'd0 ? (x + 1) % 16 : (x + 15) % 16;
        plan.push_back('{1'b1, 1'b0, 4'(x), 4'(x ^ y)});
        x = y;
      end
      plan.push_back('{1'b1, 1'b0, 4'(x), 4'd0});
      plan.push_back('{1'b0, 1'b1, 4'(x), 4'd0});
    end
  endtask
  task automatic step(input logic s, input logic [1:0] m, input logic [3:0] lv,
                      input logic [3:0] lim, input logic ab);
    ent_t e;
    start = s; mode = m; load_val = lv; limit = lim; abort = ab;
    #1;
    if (plan.size() != 0) e = plan[0];
    else e = '{1'b0, 1'b0, q_m, 4'd0};
    if (e.b && ab) e.t = 4'd0;
    oq = q; ot = t_vec; ob = busy; od = done;
    chk("q", q, e.q);
    chk("t_vec", t_vec, e.t);
    chk("busy", {3'b0, busy}, {3'b0, e.b});
    chk("done", {3'b0, done}, {3'b0, e.d});
    @(posedge clk);
    if (plan.size() == 0) begin
      if (s) build(m, lv, lim);
    end else begin
      e = plan.pop_front();
      if (e.b && ab) begin
        plan.delete();
        q_m = e.q;
      end else q_m = e.q ^ e.t;
    end
    @(negedge clk);
  endtask
  task automatic rnd_step(input logic s, input logic ab);
    step(s, 2'($urandom), 4'($urandom), 4'($urandom), ab);
  endtask
  task automatic do_reset;
    rst = 1'b0;
    #1;
    chk("rst_q", q, 4'd0);
    chk("rst_t_vec", t_vec, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_done", {3'b0, done}, 4'd0);
    plan.delete();
    q_m = 4'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic ld(input logic [3:0] v);
    step(1'b1, 2'd2, v, 4'd0, 1'b0);
    rnd_step(1'b0, 1'b0);
    rnd_step(1'b0, 1'b0);
  endtask
  initial begin
    @(negedge clk);
    do_reset;
    step(1'b1, 2'd0, 4'd0, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rnd_step(1'b0, 1'b0);
      chk("up_q", oq, up_q[i]);
      chk("up_t", ot, up_t[i]);
      chk("up_busy", {3'b0, ob}, 4'd1);
    end
    rnd_step(1'b0, 1'b0);
    chk("up_done", {3'b0, od}, 4'd1);
    rnd_step(1'b0, 1'b0);
    chk("up_done_once", {3'b0, od}, 4'd0);
    ld(4'd1);
    step(1'b1, 2'd1, 4'd0, 4'd14, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rnd_step(1'b0, 1'b0);
      chk("dn_q", oq, dn_q[i]);
      if (i == 1) chk("dn_t_at0", ot, 4'b1111);
    end
    rnd_step(1'b0, 1'b0);
    chk("dn_done", {3'b0, od}, 4'd1);
    ld(4'b0110);
    step(1'b1, 2'd2, 4'b1010, 4'd0, 1'b0);
    rnd_step(1'b0, 1'b0);
    chk("load_t", ot, 4'b1100);
    rnd_step(1'b0, 1'b0);
    chk("load_q", oq, 4'b1010);
    chk("load_done", {3'b0, od}, 4'd1);
    step(1'b1, 2'd3, 4'd0, 4'd0, 1'b0);
    rnd_step(1'b0, 1'b0);
    chk("clear_t", ot, 4'b1010);
    rnd_step(1'b0, 1'b0);
    chk("clear_q", oq, 4'd0);
    chk("clear_done", {3'b0, od}, 4'd1);
    step(1'b1, 2'd0, 4'd0, 4'd9, 1'b0);
    for (int i = 0; i < 5; i++) rnd_step(1'b1, 1'b0);
    step(1'b0, 2'd0, 4'd0, 4'd0, 1'b1);
    chk("abort_q", oq, 4'd5);
    chk("abort_t", ot, 4'd0);
    rnd_step(1'b0, 1'b0);
    chk("abort_hold_q", oq, 4'd5);
    chk("abort_idle", {3'b0, ob}, 4'd0);
    chk("abort_no_done", {3'b0, od}, 4'd0);
    ld(4'd7);
    step(1'b1, 2'd0, 4'd0, 4'd7, 1'b0);
    rnd_step(1'b0, 1'b0);
    chk("eq_t", ot, 4'd0);
    chk("eq_busy", {3'b0, ob}, 4'd1);
    rnd_step(1'b0, 1'b0);
    chk("eq_done", {3'b0, od}, 4'd1);
    chk("eq_q", oq, 4'd7);
    ld(4'd0);
    step(1'b1, 2'd0, 4'd0, 4'd15, 1'b0);
    for (int i = 0; i < 6; i++) rnd_step(1'b0, 1'b0);
    chk("pre_rst_q", q, 4'd6);
    do_reset;
    step(1'b1, 2'd0, 4'd0, 4'd2, 1'b0);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset;
      else rnd_step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
